perf_counter_bank: RTL and testbench

Parametrised bank of event counters for core performance monitoring: cycles, jumps, branches, bubbles, load-use stalls, BHT hit/fail and similar events. It generalises the fixed set of per-event counters and the display-select mux into one block with a configurable channel count and width, wrap or saturate mode, sticky overflow flags, atomic snapshot and a timed auto-scan selector. It sits beside the core, clocked by the core clock, and its read port feeds the seven-segment display path.

---
 rtl/perf_counter_bank.sv | 149 ++++++++++++++
 tb/tb_perf_counter_bank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - parametrised bank of performance event counters
//
// Counts per-channel event strobes while the core runs. Each counter either wraps
// or saturates. Overflow is recorded in a sticky per-channel flag. A snapshot
// request captures every live counter into a shadow bank in the same cycle. A
// registered read port presents one channel. The channel is chosen manually or
// by a timed auto-scan pointer.
//
// Ports:
//   clk_i        core clock, all state updates on its rising edge
//   rst_i        asynchronous active-high reset
//   en_i         global count enable
//   evt_i        per-channel event strobes, level-sampled
//   clr_i        synchronous clear of counters, shadows, flags and snapshot
//   snap_i       capture all live counters into the shadow bank
//   sel_i        manual read-channel select
//   auto_scan_i  1 = read channel rotates automatically
//   rd_ch_o      channel currently presented on rd_data_o
//   rd_data_o    registered read value (1-cycle latency)
//   ovf_o        sticky overflow flag per channel
//   snap_valid_o shadow bank holds a valid snapshot
module perf_counter_bank #(
  parameter int NumCh    = 8,
  parameter int CntBit   = 32,
  parameter int SelBit   = 4,
  parameter int Saturate = 0,
  parameter int DwellCnt = 100000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [NumCh-1:0]  evt_i,
  input  logic              clr_i,
  input  logic              snap_i,
  input  logic [SelBit-1:0] sel_i,
  input  logic              auto_scan_i,
  output logic [SelBit-1:0] rd_ch_o,
  output logic [CntBit-1:0] rd_data_o,
  output logic [NumCh-1:0]  ovf_o,
  output logic              snap_valid_o
);

  // A one-cycle dwell still needs a 1-bit counter that never leaves 0.
  localparam int DwBit = (DwellCnt > 1) ? $clog2(DwellCnt) : 1;
  localparam logic [DwBit-1:0]  DwLast  = DwBit'(DwellCnt - 1);
  localparam logic [SelBit-1:0] PtrLast = SelBit'(NumCh - 1);

  logic [CntBit-1:0] live_q   [NumCh];
  logic [CntBit-1:0] live_d   [NumCh];
  logic [CntBit-1:0] shadow_q [NumCh];
  logic [CntBit-1:0] shadow_d [NumCh];
  logic [NumCh-1:0]  ovf_q, ovf_d;
  logic              snap_valid_q, snap_valid_d;
  logic [CntBit-1:0] rd_data_q, rd_data_d;
  logic [SelBit-1:0] scan_ptr_q, scan_ptr_d;
  logic [DwBit-1:0]  dwell_q, dwell_d;

  // Counter, shadow and flag next state. Clear wins over events and snapshots.
  always_comb begin
    ovf_d        = ovf_q;
    snap_valid_d = snap_valid_q;
    for (int i = 0; i < NumCh; i++) begin
      live_d[i]   = live_q[i];
      shadow_d[i] = shadow_q[i];
    end
    if (clr_i) begin
      ovf_d        = '0;
      snap_valid_d = 1'b0;
      for (int i = 0; i < NumCh; i++) begin
        live_d[i]   = '0;
        shadow_d[i] = '0;
      end
    end else begin
      if (snap_i) begin
        snap_valid_d = 1'b1;
        for (int i = 0; i < NumCh; i++) begin
          shadow_d[i] = live_q[i];
        end
      end
      for (int i = 0; i < NumCh; i++) begin
        if (en_i && evt_i[i]) begin
          if (live_q[i] == {CntBit{1'b1}}) begin
            ovf_d[i]  = 1'b1;
            live_d[i] = (Saturate != 0) ? live_q[i] : '0;
          end else begin
            live_d[i] = live_q[i] + 1'b1;
          end
        end
      end
    end
  end

  // Dwell timer and scan pointer run on every clock while auto-scan is on.
  // When auto-scan is off, the timer is parked at 0 so the next scan gets a full dwell.
  always_comb begin
    scan_ptr_d = scan_ptr_q;
    dwell_d    = dwell_q;
    if (!auto_scan_i) begin
      dwell_d = '0;
    end else if (dwell_q == DwLast) begin
      dwell_d    = '0;
      scan_ptr_d = (scan_ptr_q == PtrLast) ? '0 : scan_ptr_q + 1'b1;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  assign rd_ch_o = auto_scan_i ? scan_ptr_q : sel_i;

  // Shadow selection uses the post-edge snapshot state. The live path uses the
  // pre-increment value. Channels beyond NumCh match no entry and read as 0.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NumCh; i++) begin
      if (rd_ch_o == SelBit'(i)) begin
        rd_data_d = snap_valid_d ? shadow_d[i] : live_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumCh; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      ovf_q        <= '0;
      snap_valid_q <= 1'b0;
      rd_data_q    <= '0;
      scan_ptr_q   <= '0;
      dwell_q      <= '0;
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        live_q[i]   <= live_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      ovf_q        <= ovf_d;
      snap_valid_q <= snap_valid_d;
      rd_data_q    <= rd_data_d;
      scan_ptr_q   <= scan_ptr_d;
      dwell_q      <= dwell_d;
    end
  end

  assign rd_data_o    = rd_data_q;
  assign ovf_o        = ovf_q;
  assign snap_valid_o = snap_valid_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - self-checking bench for perf_counter_bank (wrap and saturate instances)
module tb_perf_counter_bank;

  logic       clk, rst, en, clr, snap, auto_scan;
  logic [3:0] evt;
  logic [1:0] sel;

  logic [1:0] rd_ch_w, rd_ch_s;
  logic [3:0] rd_data_w, rd_data_s;
  logic [3:0] ovf_w, ovf_s;
  logic       snap_valid_w, snap_valid_s;

  int checks   = 0;
  int failures = 0;

  perf_counter_bank #(.NumCh(4), .CntBit(4), .SelBit(2), .Saturate(0), .DwellCnt(3)) dut_w (
    .clk_i(clk), .rst_i(rst), .en_i(en), .evt_i(evt), .clr_i(clr), .snap_i(snap),
    .sel_i(sel), .auto_scan_i(auto_scan), .rd_ch_o(rd_ch_w), .rd_data_o(rd_data_w),
    .ovf_o(ovf_w), .snap_valid_o(snap_valid_w)
  );

  perf_counter_bank #(.NumCh(4), .CntBit(4), .SelBit(2), .Saturate(1), .DwellCnt(3)) dut_s (
    .clk_i(clk), .rst_i(rst), .en_i(en), .evt_i(evt), .clr_i(clr), .snap_i(snap),
    .sel_i(sel), .auto_scan_i(auto_scan), .rd_ch_o(rd_ch_s), .rd_data_o(rd_data_s),
    .ovf_o(ovf_s), .snap_valid_o(snap_valid_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] exp_w;
    logic [3:0] exp_s;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [1:0] sel;
    logic [3:0] exp_w;
    logic [3:0] exp_s;
  } rd_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge. Pending read expectations pop here.
  task automatic step();
    sb_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.name, "_wrap"}, 32'(rd_data_w), 32'(e.exp_w));
      check({e.name, "_sat"},  32'(rd_data_s), 32'(e.exp_s));
    end
  endtask

  task automatic push_read(input string name, input logic [1:0] s,
                           input logic [3:0] ew, input logic [3:0] es);
    sb_t e;
    sel     = s;
    e.name  = name;
    e.exp_w = ew;
    e.exp_s = es;
    sb_q.push_back(e);
    step();
  endtask

  task automatic check_both_ovf(input string name, input logic [3:0] ew, input logic [3:0] es);
    check({name, "_wrap"}, 32'(ovf_w), 32'(ew));
    check({name, "_sat"},  32'(ovf_s), 32'(es));
  endtask

  rd_vec_t cnt_tbl[4];
  logic [1:0] scan_seq[13];

  initial begin
    cnt_tbl[0] = '{sel: 2'd0, exp_w: 4'd5, exp_s: 4'd5};
    cnt_tbl[1] = '{sel: 2'd1, exp_w: 4'd0, exp_s: 4'd0};
    cnt_tbl[2] = '{sel: 2'd2, exp_w: 4'd5, exp_s: 4'd5};
    cnt_tbl[3] = '{sel: 2'd3, exp_w: 4'd0, exp_s: 4'd0};
    for (int k = 0; k < 13; k++) scan_seq[k] = 2'((k / 3) % 4);

    rst = 1'b1; en = 1'b0; evt = '0; clr = 1'b0; snap = 1'b0; sel = '0; auto_scan = 1'b0;
    step(); step();
    check("reset_rd_data", 32'(rd_data_w), 0);
    check("reset_ovf", 32'(ovf_w), 0);
    check("reset_snap_valid", 32'(snap_valid_w), 0);
    check("reset_rd_ch", 32'(rd_ch_w), 0);
    rst = 1'b0;
    step();

    // Counting: 5 enabled cycles, then 3 with en low and evt still held.
    en = 1'b1; evt = 4'b0101;
    repeat (5) step();
    en = 1'b0;
    repeat (3) step();
    evt = '0;
    for (int i = 0; i < 4; i++)
      push_read($sformatf("count_ch%0d", cnt_tbl[i].sel), cnt_tbl[i].sel, cnt_tbl[i].exp_w, cnt_tbl[i].exp_s);
    check_both_ovf("count_ovf", 4'b0000, 4'b0000);

    // Reset mid-count takes effect without a clock edge.
    sel = 2'd0; en = 1'b1; evt = 4'b1111;
    repeat (3) step();
    check("pre_rst_rd_data", 32'(rd_data_w), 32'd7);
    rst = 1'b1;
    #1;
    check("async_rst_rd_data_wrap", 32'(rd_data_w), 0);
    check("async_rst_rd_data_sat", 32'(rd_data_s), 0);
    check("async_rst_ovf", 32'(ovf_w), 0);
    check("async_rst_snap_valid", 32'(snap_valid_w), 0);
    check("async_rst_rd_ch", 32'(rd_ch_w), 0);
    en = 1'b0; evt = '0;
    step();
    rst = 1'b0;
    push_read("post_rst_ch0", 2'd0, 4'd0, 4'd0);

    // Wrap versus saturate on ch1: the flag must appear only on the 16th event.
    en = 1'b1; evt = 4'b0010;
    repeat (15) step();
    check_both_ovf("ovf_at_15", 4'b0000, 4'b0000);
    step();
    check_both_ovf("ovf_at_16", 4'b0010, 4'b0010);
    step();
    en = 1'b0; evt = '0;
    push_read("wrap_ch1", 2'd1, 4'd1, 4'd15);
    push_read("wrap_ch0", 2'd0, 4'd0, 4'd0);
    check_both_ovf("ovf_sticky", 4'b0010, 4'b0010);

    // Snapshot: ch0 = 7, then snap, then 3 more events; the shadow still holds 7.
    clr = 1'b1; step(); clr = 1'b0;
    check_both_ovf("clr_ovf", 4'b0000, 4'b0000);
    en = 1'b1; evt = 4'b0001;
    repeat (7) step();
    en = 1'b0; snap = 1'b1;
    step();
    snap = 1'b0;
    check("snap_valid_set", 32'(snap_valid_w), 1);
    en = 1'b1;
    repeat (3) step();
    en = 1'b0; evt = '0;
    push_read("snap_ch0", 2'd0, 4'd7, 4'd7);
    push_read("snap_ch1", 2'd1, 4'd0, 4'd0);
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_snap_valid", 32'(snap_valid_w), 0);
    check_both_ovf("clr2_ovf", 4'b0000, 4'b0000);
    push_read("clr_ch0", 2'd0, 4'd0, 4'd0);

    // A snap that lands with an increment captures the pre-increment value.
    en = 1'b1; evt = 4'b0001;
    repeat (4) step();
    snap = 1'b1; step(); snap = 1'b0;
    en = 1'b0; evt = '0;
    push_read("snap_pre_incr", 2'd0, 4'd4, 4'd4);

    // clr, snap and events in the same cycle: clear wins.
    en = 1'b1; evt = 4'b1111;
    repeat (2) step();
    clr = 1'b1; snap = 1'b1;
    step();
    clr = 1'b0; snap = 1'b0; en = 1'b0; evt = '0;
    check("clr_snap_evt_valid", 32'(snap_valid_w), 0);
    for (int i = 0; i < 4; i++)
      push_read($sformatf("clr_all_ch%0d", i), 2'(i), 4'd0, 4'd0);

    // Auto-scan with a dwell of 3 cycles.
    auto_scan = 1'b1;
    #1;
    for (int k = 0; k < 13; k++) begin
      check($sformatf("scan_seq_%0d", k), 32'(rd_ch_w), 32'(scan_seq[k]));
      check($sformatf("scan_seq_s_%0d", k), 32'(rd_ch_s), 32'(scan_seq[k]));
      if (k != 12) step();
    end
    repeat (7) step();
    check("scan_at_2", 32'(rd_ch_w), 2);
    auto_scan = 1'b0; sel = 2'd1;
    #1;
    check("manual_sel1", 32'(rd_ch_w), 1);
    step(); step();
    sel = 2'd3;
    #1;
    check("manual_sel3", 32'(rd_ch_w), 3);
    step();
    auto_scan = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("resume_hold_%0d", k), 32'(rd_ch_w), 2);
      step();
    end
    check("resume_advance", 32'(rd_ch_w), 3);
    auto_scan = 1'b0;
    step();

    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
